// File: rtl/aes_pkg.sv
// Shared definitions for the AES round-sequencing controller: state encoding,
// datapath strobe bundle and AES-128 geometry constants.
package aes_pkg;

   localparam int AES_NR      = 10;
   localparam int AES_BYTES   = 16;
   localparam int AES_MIX_CYC = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_DATA,
      SUB,
      MIX,
      OUT
   } aes_state_e;

   // One datapath strobe per working phase; at most one is set at a time.
   typedef struct packed {
      logic ld_key;
      logic ld_data;
      logic sub_en;
      logic mix_en;
      logic out_en;
   } aes_strb_t;

   // Strobe pattern that belongs to a given phase.
   function automatic aes_strb_t strb_of(input aes_state_e s);
      aes_strb_t r;
      r = '0;
      case (s)
         LOAD_KEY:  r.ld_key  = 1'b1;
         LOAD_DATA: r.ld_data = 1'b1;
         SUB:       r.sub_en  = 1'b1;
         MIX:       r.mix_en  = 1'b1;
         OUT:       r.out_en  = 1'b1;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_byte_cnt.sv
// Phase byte/column counter: counts 0..limit, wraps to 0 after the terminal
// count, and flags the terminal count so the FSM can change phase.
module aes_byte_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       en,
   input  logic [3:0] limit,
   output logic [3:0] count,
   output logic       tc
);

   assign tc = (count == limit);

   // Count while enabled; clear wins over enable; wrap on terminal count.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (en)
         count <= tc ? 4'd0 : count + 4'd1;
   end

endmodule

// File: rtl/aes_ctrl.sv
// AES-128 iterative datapath sequencer: key load, data load, NR rounds of
// SubBytes/ShiftRows/AddRoundKey with MixColumns between rounds, then output.
// Optional feature macro: AES_CTRL_KEY_REUSE_EN (start with keep_key=1 skips
// the key load once a key has been loaded since reset).
module aes_ctrl
   import aes_pkg::*;
#(
   parameter int NR      = AES_NR,
   parameter int MIX_CYC = AES_MIX_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hold,
   input  logic       keep_key,
   output logic       ready,
   output logic       busy,
   output logic       ld_key,
   output logic       ld_data,
   output logic       sub_en,
   output logic       mix_en,
   output logic       out_en,
   output logic [3:0] byte_idx,
   output logic [3:0] round,
   output logic       last_round,
   output logic       done
);

   aes_state_e state_q;
   aes_strb_t  strb_q;
   logic [3:0] round_q;
   logic       ready_q;
   logic       last_q;
   logic       done_q;
   logic [3:0] cnt_limit;
   logic       cnt_tc;

`ifdef AES_CTRL_KEY_REUSE_EN
   logic       key_valid_q;
`else
   logic       unused_keep_key;
   assign unused_keep_key = keep_key;
`endif

   assign cnt_limit = (state_q == MIX) ? 4'(MIX_CYC - 1) : 4'(AES_BYTES - 1);

   aes_byte_cnt u_byte_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == IDLE),
      .en    (!hold && (state_q != IDLE)),
      .limit (cnt_limit),
      .count (byte_idx),
      .tc    (cnt_tc)
   );

   // Phase sequencing with registered strobes, round, ready, last_round and done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         strb_q      <= '0;
         round_q     <= '0;
         ready_q     <= 1'b1;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef AES_CTRL_KEY_REUSE_EN
         key_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (!hold) begin
            case (state_q)
               IDLE: if (start) begin
                  ready_q <= 1'b0;
`ifdef AES_CTRL_KEY_REUSE_EN
                  if (keep_key && key_valid_q) begin
                     state_q <= LOAD_DATA;
                     strb_q  <= strb_of(LOAD_DATA);
                  end else begin
                     state_q <= LOAD_KEY;
                     strb_q  <= strb_of(LOAD_KEY);
                  end
`else
                  state_q <= LOAD_KEY;
                  strb_q  <= strb_of(LOAD_KEY);
`endif
               end
               LOAD_KEY: if (cnt_tc) begin
                  state_q     <= LOAD_DATA;
                  strb_q      <= strb_of(LOAD_DATA);
`ifdef AES_CTRL_KEY_REUSE_EN
                  key_valid_q <= 1'b1;
`endif
               end
               LOAD_DATA: if (cnt_tc) begin
                  state_q <= SUB;
                  strb_q  <= strb_of(SUB);
                  round_q <= 4'd1;
                  last_q  <= (NR == 1);
               end
               SUB: if (cnt_tc) begin
                  if (round_q < 4'(NR)) begin
                     state_q <= MIX;
                     strb_q  <= strb_of(MIX);
                  end else begin
                     state_q <= OUT;
                     strb_q  <= strb_of(OUT);
                  end
               end
               MIX: if (cnt_tc) begin
                  state_q <= SUB;
                  strb_q  <= strb_of(SUB);
                  round_q <= round_q + 4'd1;
                  last_q  <= ((round_q + 4'd1) == 4'(NR));
               end
               OUT: if (cnt_tc) begin
                  state_q <= IDLE;
                  strb_q  <= '0;
                  round_q <= '0;
                  last_q  <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
               default: begin
                  state_q <= IDLE;
                  strb_q  <= '0;
                  ready_q <= 1'b1;
               end
            endcase
         end
      end
   end

   // A stalled cycle must not act on the datapath, so strobes drop with hold.
   assign ld_key     = strb_q.ld_key  & ~hold;
   assign ld_data    = strb_q.ld_data & ~hold;
   assign sub_en     = strb_q.sub_en  & ~hold;
   assign mix_en     = strb_q.mix_en  & ~hold;
   assign out_en     = strb_q.out_en  & ~hold;
   assign ready      = ready_q;
   assign busy       = ~ready_q;
   assign round      = round_q;
   assign last_round = last_q;
   assign done       = done_q;

endmodule
